// File: rtl/seq_detect_param_if.sv
// Bit-stream, pattern-reload and result signals between a serial bit source and seq_detect_param.
// match_cnt and the CNT_W parameter exist only when SEQ_DETECT_CNT_EN is defined.
interface seq_detect_param_if #(
  parameter int SEQ_LEN = 5
`ifdef SEQ_DETECT_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  localparam int SW = $clog2(SEQ_LEN + 1);

  logic               din_vld;
  logic               din;
  logic               ovl_mode;
  logic               cfg_load;
  logic [SEQ_LEN-1:0] cfg_pattern;
  logic               match;
  logic [SW-1:0]      state_o;
`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0]   match_cnt;

  modport master (output din_vld, din, ovl_mode, cfg_load, cfg_pattern,
                  input  match, state_o, match_cnt);
  modport slave  (input  din_vld, din, ovl_mode, cfg_load, cfg_pattern,
                  output match, state_o, match_cnt);
`else
  modport master (output din_vld, din, ovl_mode, cfg_load, cfg_pattern,
                  input  match, state_o);
  modport slave  (input  din_vld, din, ovl_mode, cfg_load, cfg_pattern,
                  output match, state_o);
`endif
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with run-time pattern reload and overlap select.
// Optional saturating match counter enabled by the SEQ_DETECT_CNT_EN macro.
module seq_detect_param #(
  parameter int                 SEQ_LEN = 5,
  parameter logic [SEQ_LEN-1:0] PATTERN = 5'b10010
`ifdef SEQ_DETECT_CNT_EN
  , parameter int               CNT_W   = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_param_if.slave  bus
);
  localparam int SW = $clog2(SEQ_LEN + 1);

  typedef enum logic [1:0] {OP_IDLE, OP_LOAD, OP_BIT} op_e;

  op_e                op;
  logic [SEQ_LEN-1:0] patternQ, patternD;
  logic [SW-1:0]      stateQ, stateD;
  logic               matchQ, matchD;
  logic [SW-1:0]      shiftAmt;
  logic [SEQ_LEN-1:0] hist;
  logic               full;
  logic               prefixOk;
  logic [SW-1:0]      bestK;

  always_comb begin
    op = OP_IDLE;
    if (bus.cfg_load) begin
      op = OP_LOAD;
    end else if (bus.din_vld) begin
      op = OP_BIT;
    end
  end

  // hist holds the candidate right-aligned: the matched prefix followed by din in bit 0.
  // bestK is the longest proper prefix of the pattern that ends the candidate.
  always_comb begin
    shiftAmt = SW'(SEQ_LEN) - stateQ;
    hist     = ((patternQ >> shiftAmt) << 1) | SEQ_LEN'(bus.din);
    full     = (stateQ == SW'(SEQ_LEN - 1)) && (bus.din == patternQ[0]);
    bestK    = '0;
    prefixOk = 1'b0;
    for (int k = 1; k < SEQ_LEN; k++) begin
      prefixOk = (k <= int'(stateQ) + 1);
      for (int j = 0; j < k; j++) begin
        if (hist[k-1-j] != patternQ[SEQ_LEN-1-j]) begin
          prefixOk = 1'b0;
        end
      end
      if (prefixOk) begin
        bestK = SW'(k);
      end
    end
  end

  always_comb begin
    patternD = patternQ;
    stateD   = stateQ;
    matchD   = 1'b0;
    unique case (op)
      OP_LOAD: begin
        patternD = bus.cfg_pattern;
        stateD   = '0;
      end
      OP_BIT: begin
        matchD = full;
        stateD = (full && !bus.ovl_mode) ? '0 : bestK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      patternQ <= PATTERN;
      stateQ   <= '0;
      matchQ   <= 1'b0;
    end else begin
      patternQ <= patternD;
      stateQ   <= stateD;
      matchQ   <= matchD;
    end
  end

  assign bus.match   = matchQ;
  assign bus.state_o = stateQ;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cntQ, cntD;

  // Counts cycles with match high; saturates rather than wrapping.
  always_comb begin
    cntD = cntQ;
    if (op == OP_LOAD) begin
      cntD = '0;
    end else if (matchQ && (cntQ != '1)) begin
      cntD = cntQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign bus.match_cnt = cntQ;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a history-based model pushes expected match/state/count
// per driven cycle; they are popped and compared one cycle later. Counter checks need SEQ_DETECT_CNT_EN.
module tb_seq_detect_param;
  localparam int                 SEQ_LEN = 5;
  localparam logic [SEQ_LEN-1:0] DEF_PAT = 5'b10010;
`ifdef SEQ_DETECT_CNT_EN
  localparam int                 CNT_W   = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef SEQ_DETECT_CNT_EN
  seq_detect_param_if #(.SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W)) bus ();
  seq_detect_param #(.SEQ_LEN(SEQ_LEN), .PATTERN(DEF_PAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`else
  seq_detect_param_if #(.SEQ_LEN(SEQ_LEN)) bus ();
  seq_detect_param #(.SEQ_LEN(SEQ_LEN), .PATTERN(DEF_PAT)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  typedef struct {
    int matchV;
    int stateV;
    int cntV;
  } exp_t;

  exp_t               sbQ[$];
  int                 checks = 0;
  int                 errors = 0;
  logic [SEQ_LEN-1:0] patM;
  int                 histM[$];
  int                 stateM;
  int                 matchM;
  int                 cntM;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Longest k <= maxK such that the last k accepted bits equal the first k pattern bits.
  function automatic int suffixPrefix(input int maxK);
    int  best;
    bit  ok;
    best = 0;
    for (int k = 1; k <= maxK; k++) begin
      if (k <= histM.size()) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (histM[histM.size() - k + j] != int'(patM[SEQ_LEN-1-j])) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic modelStep(input logic vld, input logic b, input logic ovl, input logic load,
                           input logic [SEQ_LEN-1:0] pat);
    int newCnt;
    newCnt = cntM;
`ifdef SEQ_DETECT_CNT_EN
    if (matchM == 1 && cntM < (1 << CNT_W) - 1) newCnt = cntM + 1;
`endif
    if (load) begin
      patM = pat;
      histM.delete();
      stateM = 0;
      matchM = 0;
      newCnt = 0;
    end else if (vld) begin
      histM.push_back(int'(b));
      if (histM.size() > SEQ_LEN) void'(histM.pop_front());
      if (suffixPrefix(SEQ_LEN) == SEQ_LEN) begin
        matchM = 1;
        if (!ovl) histM.delete();
      end else begin
        matchM = 0;
      end
      stateM = suffixPrefix(SEQ_LEN - 1);
    end else begin
      matchM = 0;
    end
    cntM = newCnt;
  endtask

  task automatic applyStimulus(input logic vld, input logic b, input logic ovl, input logic load,
                               input logic [SEQ_LEN-1:0] pat, input string tag);
    exp_t e;
    bus.din_vld     = vld;
    bus.din         = b;
    bus.ovl_mode    = ovl;
    bus.cfg_load    = load;
    bus.cfg_pattern = pat;
    modelStep(vld, b, ovl, load, pat);
    sbQ.push_back('{matchM, stateM, cntM});
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, "_match"}, 32'(bus.match), e.matchV);
      checkOutput({tag, "_state"}, 32'(bus.state_o), e.stateV);
`ifdef SEQ_DETECT_CNT_EN
      checkOutput({tag, "_cnt"}, 32'(bus.match_cnt), e.cntV);
`endif
    end
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n, input logic ovl, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, bits[i], ovl, 1'b0, '0, tag);
    end
  endtask

  task automatic modelReset();
    patM = DEF_PAT;
    histM.delete();
    stateM = 0;
    matchM = 0;
    cntM   = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [SEQ_LEN-1:0] rp;
    rst             = 1'b0;
    bus.din_vld     = 1'b0;
    bus.din         = 1'b0;
    bus.ovl_mode    = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", 32'(bus.state_o), 32'd0);
    checkOutput("rst_match", 32'(bus.match), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Overlapping detection on the default pattern.
    sendBits(16'b10010, 5, 1'b1, "tp1a");
    checkOutput("tp1_state5", 32'(bus.state_o), 32'd2);
    checkOutput("tp1_match5", 32'(bus.match), 32'd1);
    sendBits(16'b010, 3, 1'b1, "tp1b");
    checkOutput("tp1_match8", 32'(bus.match), 32'd1);

    // Non-overlapping: second occurrence suppressed.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, DEF_PAT, "tp2_load");
    sendBits(16'b10010, 5, 1'b0, "tp2a");
    checkOutput("tp2_match5", 32'(bus.match), 32'd1);
    sendBits(16'b010, 3, 1'b0, "tp2b");
    checkOutput("tp2_state8", 32'(bus.state_o), 32'd2);
    checkOutput("tp2_nomatch8", 32'(bus.match), 32'd0);

    // Idle gap holds progress.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, DEF_PAT, "tp3_load");
    sendBits(16'b100, 3, 1'b1, "tp3a");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, "tp3_gap");
      checkOutput("tp3_gap_state", 32'(bus.state_o), 32'd3);
    end
    sendBits(16'b10, 2, 1'b1, "tp3b");
    checkOutput("tp3_match", 32'(bus.match), 32'd1);

    // Reload mid-sequence.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, DEF_PAT, "tp4_pre");
    sendBits(16'b100, 3, 1'b1, "tp4a");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'b11011, "tp4_load");
    checkOutput("tp4_state_load", 32'(bus.state_o), 32'd0);
    sendBits(16'b11011, 5, 1'b1, "tp4b");
    checkOutput("tp4_match5", 32'(bus.match), 32'd1);
    sendBits(16'b011, 3, 1'b1, "tp4c");
    checkOutput("tp4_match8", 32'(bus.match), 32'd1);

    // Asynchronous reset mid-sequence.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b01101, "tp5_pre");
    sendBits(16'b01101, 5, 1'b1, "tp5_other");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, DEF_PAT, "tp5_load");
    sendBits(16'b1001, 4, 1'b1, "tp5a");
    checkOutput("tp5_state4", 32'(bus.state_o), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("tp5_rst_state", 32'(bus.state_o), 32'd0);
    checkOutput("tp5_rst_match", 32'(bus.match), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    sendBits(16'b10010, 5, 1'b1, "tp5b");
    checkOutput("tp5_match", 32'(bus.match), 32'd1);

    // Randomised traffic with occasional reloads.
    for (int i = 0; i < 300; i++) begin
      rp = SEQ_LEN'($urandom_range(0, (1 << SEQ_LEN) - 1));
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0), rp, "rnd");
    end

`ifdef SEQ_DETECT_CNT_EN
    // Saturating counter: five overlapping matches of 11111.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, "cnt_load");
    checkOutput("cnt_cleared0", 32'(bus.match_cnt), 32'd0);
    sendBits(16'h01FF, 9, 1'b1, "cnt_bits");
    checkOutput("cnt_after9", 32'(bus.match_cnt), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, "cnt_idle");
    checkOutput("cnt_sat", 32'(bus.match_cnt), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, DEF_PAT, "cnt_clr");
    checkOutput("cnt_cleared", 32'(bus.match_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-sequence detector: the successor to the fixed 5-bit Moore detector.
- Pattern length and default pattern are parameters. The pattern can be reloaded at run time. Overlapping or non-overlapping detection is selected by a mode input.
- Sits behind a serial bit source (UART/deserializer bit stream) and drives a one-cycle match pulse plus a debug view of the match progress.

Parameters:
- SEQ_LEN, 5, pattern length in bits; legal 2..16.
- PATTERN, 5'b10010, reset/default pattern, SEQ_LEN bits wide; MSB is the first bit received.
- CNT_W, 8, width of the optional match counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- din_vld  input  1  qualifies din; a bit is accepted only on cycles with din_vld=1.
- din  input  1  serial data bit.
- ovl_mode  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on each accepted bit.
- cfg_load  input  1  one-cycle strobe that loads cfg_pattern.
- cfg_pattern  input  SEQ_LEN  new pattern, same bit order as PATTERN.
- match  output  1  registered one-cycle pulse, high in the cycle after the completing bit is accepted.
- state_o  output  clog2(SEQ_LEN+1)  current matched-prefix length, for debug.
- match_cnt  output  CNT_W  saturating match count; present only with the optional feature.

Behaviour:
- Reset (rst=0, asynchronous): pattern register <= PATTERN, state <= 0, match <= 0, match_cnt <= 0.
- State machine: state S = number of leading pattern bits currently matched, 0..SEQ_LEN-1. Outputs are registered (Moore style).
- Accepted bit (din_vld=1, cfg_load=0):
  - Let candidate = the S matched bits followed by din.
  - If candidate equals the whole pattern (S = SEQ_LEN-1 and din = expected bit): match <= 1 next cycle.
    - Next S, overlap mode: the longest proper border of the pattern (prefix that is also a suffix). For 10010 this is 2.
    - Next S, non-overlap mode: 0.
  - Otherwise, next S = the largest k <= S+1 such that the last k bits of candidate equal the first k pattern bits. k may be 0.
  - Next-state logic is combinational, computed generically from the pattern register; no hard-coded state table.
- Idle cycle (din_vld=0): S holds; match <= 0.
- match is never high for two consecutive cycles unless two consecutive accepted bits each complete a match. Example: overlap mode with pattern 11 and input 1,1,1 gives match high on the 2nd and 3rd cycles.
- cfg_load=1 has priority over din_vld:
  - Pattern register <= cfg_pattern; S <= 0; match <= 0. The din on that cycle is discarded.
  - The new pattern is in effect from the next accepted bit.
- ovl_mode changes mid-stream affect only the transition taken after the next full match.
- Reset asserted mid-sequence: everything returns to reset values immediately; partial progress is lost.
- Latency: completing bit accepted at edge N, match high from edge N to edge N+1.

Optional Feature:
- Macro: SEQ_DETECT_CNT_EN.
- Defined:
  - match_cnt port exists and increments by 1 on every cycle where match is asserted.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared by reset and by cfg_load.
- Undefined: match_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Default pattern 10010, ovl_mode=1, din_vld=1, stream 1,0,0,1,0,0,1,0 -> match pulses after bit 5 and bit 8; state_o after bit 5 = 2.
- Same stream, ovl_mode=0 -> single match after bit 5; state_o after bit 8 = 2; no second pulse.
- Stream 1,0,0,1,0 with din_vld deasserted for 3 cycles between bits 3 and 4 -> state_o holds 3 during the gap; match after bit 5 only; match low during the gap.
- cfg_load with cfg_pattern=5'b11011 while state_o=3, then stream 1,1,0,1,1,0,1,1 (overlap) -> state_o=0 after the load; matches after bits 5 and 8.
- rst pulled low while state_o=4 -> state_o=0 and match=0 immediately; next stream 1,0,0,1,0 matches normally.
- With SEQ_DETECT_CNT_EN and CNT_W=2, 5 overlapping matches of pattern 11 -> match_cnt reads 1,2,3,3,3; cfg_load then clears it to 0.
